// File: rtl/fall_scheduler_if.sv
// Handshake bundle between the falling-item sequencer and its environment.
// The master modport drives the game controls; the slave (sequencer) drives playfield state.
interface fall_scheduler_if;
    logic        start;
    logic        pause;
    logic        frame_tick;
    logic [2:0]  farmer_x;
    logic [1:0]  state;
    logic [3:0]  slot_active;
    logic [11:0] slot_x;
    logic [39:0] slot_y;
    logic [3:0]  catch_pulse;
    logic [3:0]  miss_pulse;
    logic [7:0]  score_pos;
    logic [7:0]  score_neg;
    logic [11:0] time_left;
    logic        game_over;

    modport master (
        output start, pause, frame_tick, farmer_x,
        input  state, slot_active, slot_x, slot_y, catch_pulse, miss_pulse,
        input  score_pos, score_neg, time_left, game_over
    );

    modport slave (
        input  start, pause, frame_tick, farmer_x,
        output state, slot_active, slot_x, slot_y, catch_pulse, miss_pulse,
        output score_pos, score_neg, time_left, game_over
    );
endinterface

// File: rtl/fall_scheduler.sv
// Falling-item game sequencer: game FSM, timer, spawning, item motion,
// catch/miss detection against the farmer lane and saturating score keeping.
module fall_scheduler #(
    parameter int unsigned FIELD_H    = 480,
    parameter int unsigned ITEM_H     = 80,
    parameter int unsigned CATCH_Y    = 400,
    parameter int unsigned SPEED      = 4,
    parameter int unsigned SPAWN_GAP  = 120,
    parameter int unsigned GAME_TICKS = 3600,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic             clk,
    input logic             rst,
    fall_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPlay  = 2'd1,
        StPause = 2'd2,
        StOver  = 2'd3
    } state_e;

    localparam int unsigned CntW      = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam logic [9:0]  CatchTop  = 10'(CATCH_Y - ITEM_H);
    localparam logic [9:0]  MissTop   = 10'(FIELD_H - ITEM_H);
    localparam logic [9:0]  Speed     = 10'(SPEED);
    localparam logic [11:0] GameTicks = 12'(GAME_TICKS);
    localparam logic [CntW-1:0] GapLast = CntW'(SPAWN_GAP - 1);

    state_e          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [3:0]      act_q, act_d;
    logic [3:0][2:0] x_q, x_d;
    logic [3:0][9:0] y_q, y_d;
    logic [7:0]      pos_q, pos_d;
    logic [7:0]      neg_q, neg_d;
    logic [11:0]     time_q, time_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      catch_q, catch_d;
    logic [3:0]      miss_q, miss_d;
    logic            over_q, over_d;

    logic [9:0] ny;
    logic [8:0] pos_sum;
    logic [8:0] neg_sum;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        state_d = state_q;
        act_d   = act_q;
        x_d     = x_q;
        y_d     = y_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        time_d  = time_q;
        cnt_d   = cnt_q;
        catch_d = '0;
        miss_d  = '0;
        ny      = '0;
        pos_sum = {1'b0, pos_q};
        neg_sum = {1'b0, neg_q};
        idx     = '0;
        found   = 1'b0;

        unique case (state_q)
            StIdle, StOver: begin
                if (bus.start) begin
                    state_d = StPlay;
                    act_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    pos_d   = '0;
                    neg_d   = '0;
                    cnt_d   = '0;
                    time_d  = GameTicks;
                end
            end
            StPlay: begin
                if (bus.pause) state_d = StPause;
                if (bus.frame_tick) begin
                    for (int i = 0; i < 4; i++) begin
                        if (act_q[i]) begin
                            ny = y_q[i] + Speed;
                            if (ny >= CatchTop && x_q[i] == bus.farmer_x) begin
                                act_d[i]   = 1'b0;
                                x_d[i]     = '0;
                                y_d[i]     = '0;
                                catch_d[i] = 1'b1;
                                // Slot 0 is the bug; fruit slots are worth 3/2/1.
                                if (i == 0) neg_sum = neg_sum + 9'd3;
                                else        pos_sum = pos_sum + 9'(4 - i);
                            end else if (ny >= MissTop) begin
                                act_d[i]  = 1'b0;
                                x_d[i]    = '0;
                                y_d[i]    = '0;
                                miss_d[i] = 1'b1;
                            end else begin
                                y_d[i] = ny;
                            end
                        end
                    end
                    pos_d = pos_sum[8] ? 8'hFF : pos_sum[7:0];
                    neg_d = neg_sum[8] ? 8'hFF : neg_sum[7:0];

                    // Search uses pre-tick occupancy so freed slots wait a tick.
                    if (cnt_q == GapLast) begin
                        cnt_d = '0;
                        for (int k = 0; k < 4; k++) begin
                            idx = lfsr_q[1:0] + 2'(k);
                            if (!found && !act_q[idx]) begin
                                found      = 1'b1;
                                act_d[idx] = 1'b1;
                                x_d[idx]   = lfsr_q[4:2];
                                y_d[idx]   = '0;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end

                    time_d = time_q - 12'd1;
                    if (time_q == 12'd1) begin
                        state_d = StOver;
                        act_d   = '0;
                        x_d     = '0;
                        y_d     = '0;
                    end
                end
            end
            StPause: begin
                if (bus.pause) state_d = StPlay;
            end
        endcase

        over_d = (state_d == StOver);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            lfsr_q  <= LFSR_SEED;
            act_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
            time_q  <= GameTicks;
            cnt_q   <= '0;
            catch_q <= '0;
            miss_q  <= '0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            act_q   <= act_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            time_q  <= time_d;
            cnt_q   <= cnt_d;
            catch_q <= catch_d;
            miss_q  <= miss_d;
            over_q  <= over_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.slot_active = act_q;
    assign bus.slot_x      = x_q;
    assign bus.slot_y      = y_q;
    assign bus.catch_pulse = catch_q;
    assign bus.miss_pulse  = miss_q;
    assign bus.score_pos   = pos_q;
    assign bus.score_neg   = neg_q;
    assign bus.time_left   = time_q;
    assign bus.game_over   = over_q;

endmodule

// File: tb/tb_fall_scheduler.sv
// Randomized bench for fall_scheduler against a playfield model built from
// per-slot arrays; a second game steers the farmer toward falling items.
module tb_fall_scheduler;

    localparam int Gap   = 6;
    localparam int Ticks = 3600;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fall_scheduler_if bus ();

    fall_scheduler #(
        .SPAWN_GAP (Gap),
        .GAME_TICKS(Ticks)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference playfield
    int          m_state;
    bit          m_act[4];
    int          m_x[4];
    int          m_y[4];
    int          m_pos, m_neg, m_time, m_cnt;
    logic [15:0] m_lfsr;
    int          m_catch, m_miss;
    int          fx;
    int          pts[4] = '{3, 3, 2, 1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return 16'(((int'(l) << 1) | fb) & 16'hFFFF);
    endfunction

    task automatic clear_slots();
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0;
            m_x[i]   = 0;
            m_y[i]   = 0;
        end
    endtask

    task automatic model_tick(input int lf, input int lane);
        bit pre[4];
        int ny;
        int j;
        for (int i = 0; i < 4; i++) pre[i] = m_act[i];
        for (int i = 0; i < 4; i++) begin
            if (pre[i]) begin
                ny = m_y[i] + 4;
                if (ny >= 320 && m_x[i] == lane) begin
                    m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
                    m_catch |= (1 << i);
                    if (i == 0) m_neg += pts[i];
                    else        m_pos += pts[i];
                end else if (ny >= 400) begin
                    m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
                    m_miss |= (1 << i);
                end else begin
                    m_y[i] = ny;
                end
            end
        end
        if (m_pos > 255) m_pos = 255;
        if (m_neg > 255) m_neg = 255;
        if (m_cnt == Gap - 1) begin
            m_cnt = 0;
            for (int k = 0; k < 4; k++) begin
                j = ((lf & 3) + k) % 4;
                if (!pre[j]) begin
                    m_act[j] = 1;
                    m_x[j]   = (lf >> 2) & 7;
                    m_y[j]   = 0;
                    break;
                end
            end
        end else begin
            m_cnt++;
        end
        m_time--;
        if (m_time == 0) begin
            m_state = 3;
            clear_slots();
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit p, input bit t, input int lane);
        int lf;
        m_catch = 0;
        m_miss  = 0;
        if (!r) begin
            m_state = 0; clear_slots();
            m_pos = 0; m_neg = 0; m_time = Ticks; m_cnt = 0;
            m_lfsr = 16'hACE1;
            return;
        end
        lf     = int'(m_lfsr);
        m_lfsr = lfsr_next(m_lfsr);
        case (m_state)
            0, 3: if (s) begin
                m_state = 1; clear_slots();
                m_pos = 0; m_neg = 0; m_cnt = 0; m_time = Ticks;
            end
            1: begin
                if (t) model_tick(lf, lane);
                if (p && m_state == 1) m_state = 2;
            end
            default: if (p) m_state = 1;
        endcase
    endtask

    task automatic compare_all();
        logic [3:0]  ea;
        logic [11:0] ex;
        logic [39:0] ey;
        ea = '0; ex = '0; ey = '0;
        for (int i = 0; i < 4; i++) begin
            ea[i] = m_act[i];
            ex    = ex | (12'(m_x[i]) << (3 * i));
            ey    = ey | (40'(m_y[i]) << (10 * i));
        end
        check("state", bus.state, m_state);
        check("slot_active", bus.slot_active, ea);
        check("slot_x", bus.slot_x, ex);
        check("slot_y", bus.slot_y, ey);
        check("catch_pulse", bus.catch_pulse, m_catch);
        check("miss_pulse", bus.miss_pulse, m_miss);
        check("score_pos", bus.score_pos, m_pos);
        check("score_neg", bus.score_neg, m_neg);
        check("time_left", bus.time_left, m_time);
        check("game_over", bus.game_over, (m_state == 3));
    endtask

    task automatic step(input bit s, input bit p, input bit t);
        bus.start      = s;
        bus.pause      = p;
        bus.frame_tick = t;
        bus.farmer_x   = 3'(fx);
        model_edge(rst, s, p, t, fx);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Steer toward the lowest falling item
    task automatic track_farmer();
        int best;
        best = -1;
        for (int i = 0; i < 4; i++)
            if (m_act[i] && (best < 0 || m_y[i] > m_y[best])) best = i;
        if (best >= 0) fx = m_x[best];
    endtask

    task automatic random_cycle();
        int r;
        r = $urandom_range(0, 99);
        if ($urandom_range(0, 19) == 0) fx = $urandom_range(0, 7);
        if (r < 70)      step(0, 0, 1);
        else if (r < 73) step(0, 1, 0);
        else if (r < 75) step(1, 0, 0);
        else if (r < 76) step(1, 1, 0);
        else             step(0, 0, 0);
    endtask

    initial begin
        int cyc;
        fx = 0;
        bus.start = 0; bus.pause = 0; bus.frame_tick = 0; bus.farmer_x = 0;
        rst = 0;
        @(posedge clk); #1;
        step(0, 0, 0);
        step(1, 0, 1);
        rst = 1;
        step(0, 1, 1);
        step(0, 0, 0);

        // Game 1: random controls and lanes
        step(1, 0, 0);
        cyc = 0;
        while (m_state != 3 && cyc < 40000) begin
            random_cycle();
            cyc++;
        end
        check("game1_over", bus.state, 2'd3);

        for (int i = 0; i < 5; i++) step(0, 1, 1);

        // Game 2: farmer follows items, drives scores into saturation
        step(1, 1, 0);
        cyc = 0;
        while (m_state != 3 && cyc < 10000) begin
            track_farmer();
            step(0, 0, 1);
            cyc++;
        end
        check("game2_over", bus.state, 2'd3);

        // Game 3: aborted by reset mid-game
        step(1, 0, 0);
        for (int i = 0; i < 300; i++) random_cycle();
        rst = 0;
        step(0, 0, 1);
        rst = 1;
        step(0, 0, 1);
        step(1, 0, 0);
        for (int i = 0; i < 200; i++) random_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fall_scheduler.md
Name: fall_scheduler

Overview:
- Game sequencer for the falling-item playfield: owns the IDLE/PLAY/PAUSE/OVER state machine, the game timer, item spawning, per-frame item motion, catch/miss detection against farmer_x, and score accumulation.
- Drives four item slots: slot0 = bug, slot1 = green, slot2 = orange, slot3 = yellow.
- Pixel-address generators read slot_active/slot_x/slot_y for rendering. The scoreboard reads score_pos/score_neg.

Parameters:
- FIELD_H, 480, playfield height in pixels.
- ITEM_H, 80, item and farmer sprite height.
- CATCH_Y, 400, top row of the farmer sprite.
- SPEED, 4, pixels per frame_tick of fall.
- SPAWN_GAP, 120, frame_ticks between spawn attempts.
- GAME_TICKS, 3600, frame_ticks per game.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse: begin a new game.
- pause  in  1  one-cycle pulse: toggle pause.
- frame_tick  in  1  one-cycle pulse, once per video frame.
- farmer_x  in  3  farmer lane, 0..7.
- state  out  2  0 = IDLE, 1 = PLAY, 2 = PAUSE, 3 = OVER.
- slot_active  out  4  bit i: slot i is falling.
- slot_x  out  12  lane of slot i at bits [3i+2:3i].
- slot_y  out  40  top row of slot i at bits [10i+9:10i].
- catch_pulse  out  4  one-cycle pulse per caught slot.
- miss_pulse  out  4  one-cycle pulse per missed slot.
- score_pos  out  8  fruit points, saturating.
- score_neg  out  8  bug points, saturating.
- time_left  out  12  remaining frame_ticks.
- game_over  out  1  high while state == OVER.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - state = IDLE; slot_active, slot_x, slot_y = 0.
  - score_pos = score_neg = 0; catch_pulse = miss_pulse = 0.
  - time_left = GAME_TICKS; spawn counter = 0; LFSR = LFSR_SEED.
  - Reset mid-game aborts everything.
- All outputs are registered. Every effect of a frame_tick is visible on the cycle after that tick's clock edge.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11. Advances every cycle in every state except during reset.
- State transitions:
  - IDLE --start--> PLAY.
  - PLAY --pause--> PAUSE.
  - PAUSE --pause--> PLAY.
  - PLAY --time_left reaches 0--> OVER.
  - OVER --start--> PLAY.
  - start in PLAY or PAUSE is ignored. pause in IDLE or OVER is ignored.
  - start and pause in the same cycle: in IDLE/OVER, start wins; in PLAY/PAUSE, pause wins.
- Entering PLAY from IDLE/OVER: clear scores, slots and spawn counter; set time_left = GAME_TICKS.
- PAUSE freezes all slot, score, timer and spawn state. frame_tick is ignored.
- PLAY, on each frame_tick, evaluated in this order on pre-tick slot state:
  1. Move: for each active slot, ny = slot_y + SPEED.
  2. Catch: if ny >= CATCH_Y - ITEM_H and slot_x == farmer_x:
     - clear the slot and pulse catch_pulse[i];
     - add points: slot0 adds 3 to score_neg; slots 1/2/3 add 3/2/1 to score_pos;
     - sums clamp at 255;
     - multiple catches in one tick all add.
  3. Miss: otherwise, if ny >= FIELD_H - ITEM_H, clear the slot and pulse miss_pulse[i]. Score is unchanged.
  4. Otherwise slot_y = ny.
  5. Spawn counter increments. On reaching SPAWN_GAP - 1 it wraps to 0 and attempts a spawn:
     - candidate = LFSR[1:0]; if that slot was active pre-tick, search upward mod 4 for the first inactive slot;
     - if none is free, skip the spawn;
     - the chosen slot gets active = 1, x = LFSR[4:2], y = 0, and is not moved this tick;
     - a slot freed this tick is not reused until the next tick.
  6. time_left decrements. When it becomes 0: state = OVER, all slots cleared, pulses still emitted for this tick's catches/misses.
- catch_pulse and miss_pulse are 0 on every cycle other than the one following a processed frame_tick.
- Width rule: the maximum slot_y is FIELD_H - ITEM_H - 1 + SPEED, which is < 1024; 10-bit y never overflows.

Test Plan:
- Reset: hold rst = 0 for 2 cycles -> state = 0, slot_active = 0, scores = 0, time_left = 3600, game_over = 0.
- Spawn: start, then 120 frame_ticks -> exactly one slot_active bit set, that slot_y = 0, slot_x = LFSR[4:2] at that tick; time_left = 3480.
- Catch: set farmer_x to the spawned lane, then 80 more ticks -> on the tick where y would reach 320, catch_pulse bit i set for one cycle, slot cleared, score increased by the slot's points (bug -> score_neg = 3).
- Miss: farmer_x on another lane, 100 ticks after spawn -> miss_pulse bit i for one cycle, slot cleared, scores unchanged.
- Pause: pulse pause mid-fall, apply 50 ticks -> slot_y and time_left unchanged, state = 2. Pulse pause again -> the next tick moves y by 4.
- Timeout/restart: GAME_TICKS = 10; after 10 ticks -> state = 3, game_over = 1, slot_active = 0. Start -> state = 1, scores = 0, time_left = 10. Saturation: force 86 green catches -> score_pos = 255.
